// File: rtl/cfs_apb_cfg_master.sv
// APB master for the aligner register block: runs CONFIG (CTRL, IRQEN writes) and
// IRQ SERVICE (IRQ read, write-1-to-clear) jobs over one APB port.
module cfs_apb_cfg_master #(
  parameter int APB_ADDR_WIDTH  = 16,
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 16,
  localparam int ALGN_SIZE_WIDTH   = $clog2(ALGN_DATA_WIDTH/8) + 1,
  localparam int ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH/8)
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         cfg_req,
  input  logic [ALGN_SIZE_WIDTH-1:0]   cfg_size,
  input  logic [ALGN_OFFSET_WIDTH-1:0] cfg_offset,
  input  logic                         cfg_clr,
  input  logic [4:0]                   cfg_irqen,
  output logic                         cfg_ack,
  output logic                         cfg_err,
  input  logic                         irq,
  output logic                         irq_evt_valid,
  output logic [4:0]                   irq_evt_bits,
  output logic                         irq_evt_err,
  output logic                         busy,
  output logic [APB_ADDR_WIDTH-1:0]    paddr,
  output logic                         pwrite,
  output logic                         psel,
  output logic                         penable,
  output logic [31:0]                  pwdata,
  input  logic                         pready,
  input  logic [31:0]                  prdata,
  input  logic                         pslverr
);

  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CTRL  = APB_ADDR_WIDTH'(16'h0000);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_IRQEN = APB_ADDR_WIDTH'(16'h00F0);
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_IRQ   = APB_ADDR_WIDTH'(16'h00F4);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t state, state_nxt;

  logic                         irq_pend, cfg_pend;
  logic                         job_irq;   // 1: IRQ SERVICE, 0: CONFIG
  logic                         step;      // transfer index within the job
  logic                         err;
  logic [4:0]                   bits;
  logic [ALGN_SIZE_WIDTH-1:0]   size_q;
  logic [ALGN_OFFSET_WIDTH-1:0] offset_q;
  logic                         clr_q;
  logic [4:0]                   irqen_q;
  logic [TW-1:0]                tcnt;
  logic [31:0]                  ctrl_word;

  logic accept_irq, accept_cfg, xfer_end, xfer_err, tmo, advance;
  logic unused_prdata;

  assign unused_prdata = ^prdata[31:5];

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept_irq = 1'b0;
    accept_cfg = 1'b0;
    xfer_end   = 1'b0;
    xfer_err   = 1'b0;
    tmo        = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (irq_pend) begin
          accept_irq = 1'b1;
          state_nxt  = SETUP;
        end else if (cfg_pend) begin
          accept_cfg = 1'b1;
          state_nxt  = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        tmo      = (TIMEOUT_CYCLES != 0) && !pready && (tcnt == TMO_LAST);
        xfer_end = pready || tmo;
        xfer_err = tmo || (pready && pslverr);
        if (xfer_end) begin
          // A failed first transfer, or an empty IRQ read, ends the job early.
          advance   = !step && !xfer_err && (!job_irq || (prdata[4:0] != 5'd0));
          state_nxt = advance ? SETUP : DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      irq_pend <= 1'b0;
      cfg_pend <= 1'b0;
      job_irq  <= 1'b0;
      step     <= 1'b0;
      err      <= 1'b0;
      bits     <= '0;
      size_q   <= '0;
      offset_q <= '0;
      clr_q    <= 1'b0;
      irqen_q  <= '0;
      tcnt     <= '0;
    end else begin
      irq_pend <= irq | (irq_pend & ~accept_irq);
      // cfg_req goes through a register so it lines up with irq_pend in arbitration;
      // the DONE mask keeps a request still held on its ack cycle from re-firing.
      cfg_pend <= cfg_req & ~((state == DONE) & ~job_irq);
      if (accept_irq || accept_cfg) begin
        job_irq <= accept_irq;
        step    <= 1'b0;
        err     <= 1'b0;
        bits    <= '0;
      end
      if (accept_cfg) begin
        size_q   <= cfg_size;
        offset_q <= cfg_offset;
        clr_q    <= cfg_clr;
        irqen_q  <= cfg_irqen;
      end
      if (state == SETUP)                tcnt <= '0;
      else if (state == ACCESS && !pready) tcnt <= tcnt + 1'b1;
      if (xfer_end) begin
        if (xfer_err) err <= 1'b1;
        if (job_irq && !step) bits <= xfer_err ? 5'd0 : prdata[4:0];
        if (advance) step <= 1'b1;
      end
    end
  end

  always_comb begin
    ctrl_word                        = '0;
    ctrl_word[16]                    = clr_q;
    ctrl_word[8 +: ALGN_OFFSET_WIDTH] = offset_q;
    ctrl_word[0 +: ALGN_SIZE_WIDTH]  = size_q;
  end

  // APB outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    psel    = 1'b0;
    penable = 1'b0;
    paddr   = '0;
    pwrite  = 1'b0;
    pwdata  = '0;
    if (state == SETUP || state == ACCESS) begin
      psel    = 1'b1;
      penable = (state == ACCESS);
      if (job_irq) begin
        paddr  = ADDR_IRQ;
        pwrite = step;
        pwdata = step ? {27'b0, bits} : 32'd0;
      end else begin
        paddr  = step ? ADDR_IRQEN : ADDR_CTRL;
        pwrite = 1'b1;
        pwdata = step ? {27'b0, irqen_q} : ctrl_word;
      end
    end
  end

  assign busy          = (state != IDLE);
  assign cfg_ack       = (state == DONE) && !job_irq;
  assign cfg_err       = cfg_ack && err;
  assign irq_evt_valid = (state == DONE) && job_irq;
  assign irq_evt_bits  = irq_evt_valid ? bits : 5'd0;
  assign irq_evt_err   = irq_evt_valid && err;

endmodule

// File: tb/tb_cfs_apb_cfg_master.sv
// Bench for cfs_apb_cfg_master: APB slave model, scoreboard queues for APB transfers
// and job results, a vector table plus hand-written reset/arbitration/timeout sequences.
module tb_cfs_apb_cfg_master;

  logic        pclk, preset;
  logic        cfg_req, cfg_clr, irq;
  logic [2:0]  cfg_size;
  logic [1:0]  cfg_offset;
  logic [4:0]  cfg_irqen;
  logic        cfg_ack, cfg_err, irq_evt_valid, irq_evt_err, busy;
  logic [4:0]  irq_evt_bits;
  logic [15:0] paddr;
  logic        pwrite, psel, penable, pready, pslverr;
  logic [31:0] pwdata, prdata;

  cfs_apb_cfg_master #(.APB_ADDR_WIDTH(16), .ALGN_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .preset(preset),
    .cfg_req(cfg_req), .cfg_size(cfg_size), .cfg_offset(cfg_offset), .cfg_clr(cfg_clr),
    .cfg_irqen(cfg_irqen), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .irq(irq), .irq_evt_valid(irq_evt_valid), .irq_evt_bits(irq_evt_bits), .irq_evt_err(irq_evt_err),
    .busy(busy), .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge pclk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- APB slave model ----------------
  int          slv_wait = 0;
  bit          slv_hang = 0;
  bit          slv_err_en = 0;
  logic [15:0] slv_err_addr = '0;
  bit          slv_err_wr = 0;
  logic [31:0] slv_rdata = '0;
  int          acc_cnt = 0;

  initial begin
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
  end

  always @(negedge pclk) begin
    if (psel && penable) begin
      if (!slv_hang && acc_cnt == slv_wait) begin
        pready  = 1'b1;
        pslverr = slv_err_en && (paddr == slv_err_addr) && (pwrite == slv_err_wr);
        prdata  = pwrite ? 32'd0 : slv_rdata;
      end else begin
        pready = 1'b0; pslverr = 1'b0;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [31:0] data;
  } apb_t;

  typedef struct {
    logic [4:0] bits;
    logic       err;
  } evt_t;

  apb_t exp_apb[$];
  logic exp_cfg[$];
  evt_t exp_irq[$];
  apb_t cur;

  always @(negedge pclk) begin
    if (!preset) begin
      if (psel && !penable) begin
        if (exp_apb.size() == 0) begin
          checks++; errors++;
          $display("FAIL apb_unexpected: got addr 0x%0h wr %0d data 0x%0h, expected no transfer", paddr, pwrite, pwdata);
        end else begin
          cur = exp_apb.pop_front();
          chk("apb_addr", 32'(paddr), 32'(cur.addr));
          chk("apb_write", 32'(pwrite), 32'(cur.wr));
          chk("apb_wdata", pwdata, cur.data);
        end
      end
      if (psel && penable)
        chk("apb_access_stable", {paddr, 15'd0, pwrite} ^ pwdata, {cur.addr, 15'd0, cur.wr} ^ cur.data);
      if (!busy && !psel)
        chk("idle_apb_zero", {paddr, 15'd0, pwrite} | pwdata | 32'(penable), 32'd0);
      if (cfg_ack) begin
        if (exp_cfg.size() == 0) begin
          checks++; errors++;
          $display("FAIL cfg_ack_unexpected: got cfg_ack=1, expected none");
        end else chk("cfg_err", 32'(cfg_err), 32'(exp_cfg.pop_front()));
      end
      if (irq_evt_valid) begin
        if (exp_irq.size() == 0) begin
          checks++; errors++;
          $display("FAIL irq_evt_unexpected: got irq_evt_valid=1, expected none");
        end else begin
          evt_t e;
          e = exp_irq.pop_front();
          chk("irq_evt_bits", 32'(irq_evt_bits), 32'(e.bits));
          chk("irq_evt_err", 32'(irq_evt_err), 32'(e.err));
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_irq;
    logic [2:0]  size;
    logic [1:0]  offset;
    logic        clr;
    logic [4:0]  irqen;
    logic [31:0] rdata;
    int          waits;
    bit          err_en;
    logic [15:0] err_addr;
    bit          err_wr;
    logic [31:0] exp_ctrl;
    logic        exp_err;
    logic [4:0]  exp_bits;
  } vec_t;

  vec_t vecs[9];

  task automatic push_cfg(input logic [31:0] ctrl, input logic [4:0] ien, input int n, input logic e);
    exp_apb.push_back('{16'h0000, 1'b1, ctrl});
    if (n == 2) exp_apb.push_back('{16'h00F0, 1'b1, {27'b0, ien}});
    exp_cfg.push_back(e);
  endtask

  task automatic push_irq(input logic [4:0] b, input int n, input logic e);
    exp_apb.push_back('{16'h00F4, 1'b0, 32'd0});
    if (n == 2) exp_apb.push_back('{16'h00F4, 1'b1, {27'b0, b}});
    exp_irq.push_back('{b, e});
  endtask

  task automatic wait_out(input string name, input bit want_irq, input int budget, output int n);
    n = 0;
    do begin
      @(posedge pclk); #1; n++;
    end while (!(want_irq ? irq_evt_valid : cfg_ack) && n < budget);
    if (!(want_irq ? irq_evt_valid : cfg_ack)) begin
      checks++; errors++;
      $display("FAIL %s: got no completion pulse, expected one within %0d cycles", name, budget);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n, ntr, lat;
    bit fin;
    slv_wait = v.waits; slv_hang = 0; slv_rdata = v.rdata;
    slv_err_en = v.err_en; slv_err_addr = v.err_addr; slv_err_wr = v.err_wr;
    if (v.is_irq) begin
      ntr = ((v.err_en && !v.err_wr) || v.rdata[4:0] == 5'd0) ? 1 : 2;
      push_irq(v.exp_bits, ntr, v.exp_err);
      irq = 1'b1;
    end else begin
      ntr = (v.err_en && v.err_wr && v.err_addr == 16'h0000) ? 1 : 2;
      push_cfg(v.exp_ctrl, v.irqen, ntr, v.exp_err);
      cfg_size = v.size; cfg_offset = v.offset; cfg_clr = v.clr; cfg_irqen = v.irqen;
      cfg_req = 1'b1;
    end
    lat = 2 + ntr * (2 + v.waits);
    n = 0; fin = 0;
    while (!fin && n < 200) begin
      @(posedge pclk); #1; n++;
      if (n == 1) irq = 1'b0;
      if (n == 2) begin  // job already latched; these changes must be ignored
        cfg_size = ~v.size; cfg_offset = ~v.offset; cfg_clr = ~v.clr; cfg_irqen = ~v.irqen;
      end
      fin = v.is_irq ? irq_evt_valid : cfg_ack;
    end
    cfg_req = 1'b0;
    chk($sformatf("vec%0d_latency", idx), n, lat);
    idle(2);
    chk($sformatf("vec%0d_apb_drained", idx), exp_apb.size(), 0);
    chk($sformatf("vec%0d_busy_after", idx), 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t1, t2, t3, acc;

    vecs[0] = '{1'b0, 3'd2, 2'd0, 1'b1, 5'h1F, 32'h0,        0, 1'b0, 16'h0000, 1'b0, 32'h0001_0002, 1'b0, 5'h00};
    vecs[1] = '{1'b0, 3'd3, 2'd0, 1'b0, 5'h03, 32'h0,        1, 1'b1, 16'h0000, 1'b1, 32'h0000_0003, 1'b1, 5'h00};
    vecs[2] = '{1'b1, 3'd0, 2'd0, 1'b0, 5'h00, 32'h0000_0012, 0, 1'b0, 16'h0000, 1'b0, 32'h0,         1'b0, 5'h12};
    vecs[3] = '{1'b1, 3'd0, 2'd0, 1'b0, 5'h00, 32'h0000_0000, 0, 1'b0, 16'h0000, 1'b0, 32'h0,         1'b0, 5'h00};
    vecs[4] = '{1'b1, 3'd0, 2'd0, 1'b0, 5'h00, 32'h0000_000F, 0, 1'b1, 16'h00F4, 1'b0, 32'h0,         1'b1, 5'h00};
    vecs[5] = '{1'b1, 3'd0, 2'd0, 1'b0, 5'h00, 32'h0000_0005, 2, 1'b1, 16'h00F4, 1'b1, 32'h0,         1'b1, 5'h05};
    vecs[6] = '{1'b0, 3'd4, 2'd3, 1'b0, 5'h0A, 32'h0,        3, 1'b1, 16'h00F0, 1'b1, 32'h0000_0304, 1'b1, 5'h00};
    vecs[7] = '{1'b0, 3'd1, 2'd2, 1'b1, 5'h11, 32'h0,        2, 1'b0, 16'h0000, 1'b0, 32'h0001_0201, 1'b0, 5'h00};
    vecs[8] = '{1'b1, 3'd0, 2'd0, 1'b0, 5'h00, 32'hFFFF_FFE3, 1, 1'b0, 16'h0000, 1'b0, 32'h0,         1'b0, 5'h03};

    preset = 1'b1; cfg_req = 1'b0; irq = 1'b0;
    cfg_size = '0; cfg_offset = '0; cfg_clr = 1'b0; cfg_irqen = '0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_ack", 32'(cfg_ack), 0);
    chk("rst_irq_evt_valid", 32'(irq_evt_valid), 0);
    chk("rst_paddr", 32'(paddr), 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pwrite", 32'(pwrite), 0);
    #1 preset = 1'b0;
    idle(2);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // cfg_req and irq together: IRQ first, CONFIG next, then an irq raised during CONFIG
    slv_wait = 0; slv_hang = 0; slv_err_en = 0; slv_rdata = 32'h0000_0009;
    push_irq(5'h09, 2, 1'b0);
    push_cfg(32'h0001_0102, 5'h04, 2, 1'b0);
    push_irq(5'h09, 2, 1'b0);
    cfg_size = 3'd2; cfg_offset = 2'd1; cfg_clr = 1'b1; cfg_irqen = 5'h04;
    cfg_req = 1'b1; irq = 1'b1;
    @(posedge pclk); #1 irq = 1'b0;
    wait_out("arb_irq_first", 1'b1, 50, n); t1 = cyc;
    idle(3);
    chk("arb_cfg_busy_when_irq2", 32'(busy && !psel || busy && psel), 1);
    irq = 1'b1;
    @(posedge pclk); #1 irq = 1'b0;
    wait_out("arb_cfg", 1'b0, 50, n); t2 = cyc;
    cfg_req = 1'b0;
    wait_out("arb_irq_second", 1'b1, 50, n); t3 = cyc;
    chk("arb_irq_before_cfg", 32'(t1 < t2), 1);
    chk("arb_irq2_after_cfg", 32'(t3 > t2), 1);
    idle(2);
    chk("arb_apb_drained", exp_apb.size(), 0);

    // pready stuck low: psel drops after 16 ACCESS cycles and CONFIG reports an error
    slv_hang = 1;
    push_cfg(32'h0000_0001, 5'h02, 1, 1'b1);
    cfg_size = 3'd1; cfg_offset = 2'd0; cfg_clr = 1'b0; cfg_irqen = 5'h02;
    cfg_req = 1'b1;
    acc = 0; n = 0;
    do begin
      @(negedge pclk); n++;
      if (psel && penable) acc++;
    end while (!cfg_ack && n < 300);
    cfg_req = 1'b0;
    chk("tmo_access_cycles", acc, 16);
    chk("tmo_psel_low_at_ack", 32'(psel), 0);
    slv_hang = 0;
    idle(2);
    chk("tmo_apb_drained", exp_apb.size(), 0);

    // reset during the IRQEN access: immediate abort, CONFIG restarts from CTRL
    slv_wait = 3;
    push_cfg(32'h0001_0002, 5'h1F, 2, 1'b0);
    cfg_size = 3'd2; cfg_offset = 2'd0; cfg_clr = 1'b1; cfg_irqen = 5'h1F;
    cfg_req = 1'b1;
    n = 0;
    do begin
      @(negedge pclk); n++;
    end while (!(psel && penable && paddr == 16'h00F0) && n < 100);
    chk("rstmid_reached_irqen", 32'(psel && penable && paddr == 16'h00F0), 1);
    #1 preset = 1'b1;
    #1;
    chk("rstmid_psel", 32'(psel), 0);
    chk("rstmid_penable", 32'(penable), 0);
    chk("rstmid_busy", 32'(busy), 0);
    exp_cfg.delete();
    chk("rstmid_apb_drained", exp_apb.size(), 0);
    push_cfg(32'h0001_0002, 5'h1F, 2, 1'b0);
    @(posedge pclk); @(posedge pclk); #2 preset = 1'b0;
    wait_out("rstmid_restart", 1'b0, 100, n);
    cfg_req = 1'b0;
    idle(3);
    chk("rstmid_restart_drained", exp_apb.size(), 0);
    chk("rstmid_no_extra_ack", exp_cfg.size() + exp_irq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
